// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port to one-port memory arbiter, port b priority.
// Define MEM_ARBITER_RR_EN to alternate grants on simultaneous requests.
module mem_arbiter #(
   parameter int WIDTH = 16,
   parameter int MASKW = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_read_a,
   input  logic             mem_write_a,
   input  logic [15:0]      mem_address_a,
   input  logic [WIDTH-1:0] mem_wdata_a,
   input  logic [MASKW-1:0] mem_wmask_a,
   output logic             mem_resp_a,
   output logic [WIDTH-1:0] mem_rdata_a,
   input  logic             mem_read_b,
   input  logic             mem_write_b,
   input  logic [15:0]      mem_address_b,
   input  logic [WIDTH-1:0] mem_wdata_b,
   input  logic [MASKW-1:0] mem_wmask_b,
   output logic             mem_resp_b,
   output logic [WIDTH-1:0] mem_rdata_b,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic [15:0]      pmem_address,
   output logic [WIDTH-1:0] pmem_wdata,
   output logic [MASKW-1:0] pmem_wmask,
   input  logic             pmem_resp,
   input  logic [WIDTH-1:0] pmem_rdata
);

   typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

   state_t           state;
   state_t           state_next;
   logic             pend_a;
   logic             pend_b;
   logic             grant_b;
   logic             req_read;
   logic             req_write;
   logic [15:0]      req_address;
   logic [WIDTH-1:0] req_wdata;
   logic [MASKW-1:0] req_wmask;

   assign pend_a = mem_read_a | mem_write_a;
   assign pend_b = mem_read_b | mem_write_b;

`ifdef MEM_ARBITER_RR_EN
   // last_grant = 1 means port b won the previous arbitration
   logic last_grant;

   assign grant_b = pend_b & (~pend_a | ~last_grant);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_grant <= 1'b1;
      else if (state == IDLE && (pend_a || pend_b))
         last_grant <= grant_b;
   end
`else
   assign grant_b = pend_b;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_b)
               state_next = SERVE_B;
            else if (pend_a)
               state_next = SERVE_A;
         end
         SERVE_A, SERVE_B: begin
            if (pmem_resp)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A combined read+write request is captured as a write only
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_read    <= 1'b0;
         req_write   <= 1'b0;
         req_address <= '0;
         req_wdata   <= '0;
         req_wmask   <= '0;
      end else if (state_next == SERVE_B && state == IDLE) begin
         req_read    <= mem_read_b & ~mem_write_b;
         req_write   <= mem_write_b;
         req_address <= mem_address_b;
         req_wdata   <= mem_wdata_b;
         req_wmask   <= mem_wmask_b;
      end else if (state_next == SERVE_A && state == IDLE) begin
         req_read    <= mem_read_a & ~mem_write_a;
         req_write   <= mem_write_a;
         req_address <= mem_address_a;
         req_wdata   <= mem_wdata_a;
         req_wmask   <= mem_wmask_a;
      end else if (state != IDLE && pmem_resp) begin
         req_read    <= 1'b0;
         req_write   <= 1'b0;
      end
   end

   assign pmem_read    = req_read;
   assign pmem_write   = req_write;
   assign pmem_address = req_address;
   assign pmem_wdata   = req_wdata;
   assign pmem_wmask   = req_wmask;

   assign mem_resp_a  = (state == SERVE_A) & pmem_resp;
   assign mem_resp_b  = (state == SERVE_B) & pmem_resp;
   assign mem_rdata_a = pmem_rdata;
   assign mem_rdata_b = pmem_rdata;

endmodule
